// File: rtl/cla_seq_adder_pkg.sv
// ============================================================================
// cla_seq_adder_pkg : shared state encoding and sizing helper for cla_seq_adder
// Rev 1.0
// ============================================================================
`default_nettype none

package cla_seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_seq_adder_if.sv
// ============================================================================
// cla_seq_adder_if : operand/result handshake bundle for cla_seq_adder
// Rev 1.0
// ============================================================================
`default_nettype none

interface cla_seq_adder_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

`default_nettype wire

// File: rtl/cla_seq_adder_cla.sv
// ============================================================================
// cla_seq_adder_cla : single-slice carry-lookahead adder, S = A + B + C_in
// Rev 1.0
// ============================================================================
`default_nettype none

module cla_seq_adder_cla #(
  parameter int Width = 8
) (
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             C_in,
  output logic [Width-1:0] S,
  output logic             C_out
);
  logic [Width-1:0] g;
  logic [Width-1:0] p;
  logic [Width:0]   c;
  logic             term;
  logic             prop;

  assign g = A & B;
  assign p = A ^ B;

  // Each carry is the flattened sum-of-products of all lower generate terms.
  always_comb begin
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = C_in;
    for (int i = 0; i < Width; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & C_in);
    end
  end

  assign S     = p ^ c[Width-1:0];
  assign C_out = c[Width];

endmodule

`default_nettype wire

// File: rtl/cla_seq_adder.sv
// ============================================================================
// cla_seq_adder : multi-cycle Width*Chunks-bit adder built on one narrow CLA
// Rev 1.0
// ============================================================================
`default_nettype none

module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int Width  = 8,
  parameter int Chunks = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cla_seq_adder_if.slave bus
);
  localparam int W  = Width * Chunks;
  localparam int IW = (Chunks > 1) ? clog2(Chunks) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(Chunks - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             carry_reg;
  logic             c_out_reg;
  logic             ovf_reg;
  logic             in_ready;
  logic             accept;
  logic             last;
  logic [Width-1:0] sl_a;
  logic [Width-1:0] sl_b;
  logic [Width-1:0] sl_s;
  logic             sl_c;

  assign sl_a = a_reg[int'(idx)*Width +: Width];
  assign sl_b = b_reg[int'(idx)*Width +: Width];

  cla_seq_adder_cla #(.Width(Width)) u_cla (
    .A     (sl_a),
    .B     (sl_b),
    .C_in  (carry_reg),
    .S     (sl_s),
    .C_out (sl_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DONE forwards out_ready to in_ready so a new operand set can ride the
  // same edge that retires the current result.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ADD;
      end
      ADD: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) state_nxt = bus.in_valid ? ADD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = bus.in_valid & in_ready;
  assign last   = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      carry_reg <= bus.c_in;
      idx       <= '0;
    end else if (state == ADD) begin
      sum_reg[int'(idx)*Width +: Width] <= sl_s;
      carry_reg <= sl_c;
      if (last) begin
        idx       <= '0;
        c_out_reg <= sl_c;
        // Top slice result is the final sum MSB, so take it straight from the CLA.
        ovf_reg   <= (a_reg[W-1] ~^ b_reg[W-1]) & (sl_s[Width-1] ^ a_reg[W-1]);
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.ovf       = ovf_reg;

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
// ============================================================================
// tb_cla_seq_adder : directed and random checks of cla_seq_adder in 3 configs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cla_seq_adder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_seq_adder_if #(.W(32)) bus0 ();
  cla_seq_adder_if #(.W(8))  bus1 ();
  cla_seq_adder_if #(.W(12)) bus2 ();

  cla_seq_adder #(.Width(8), .Chunks(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cla_seq_adder #(.Width(8), .Chunks(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  cla_seq_adder #(.Width(4), .Chunks(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        iv[3];
  logic        ic[3];
  logic        ordy[3];
  logic [31:0] ia[3];
  logic [31:0] ib[3];
  logic        ov[3];
  logic        ir[3];
  logic        co[3];
  logic        of[3];
  logic [31:0] sm[3];
  int          wd[3]  = '{32, 8, 12};
  int          lat[3] = '{4, 1, 3};

  assign bus0.in_valid = iv[0];  assign bus0.c_in = ic[0];  assign bus0.out_ready = ordy[0];
  assign bus1.in_valid = iv[1];  assign bus1.c_in = ic[1];  assign bus1.out_ready = ordy[1];
  assign bus2.in_valid = iv[2];  assign bus2.c_in = ic[2];  assign bus2.out_ready = ordy[2];
  assign bus0.a = ia[0];         assign bus0.b = ib[0];
  assign bus1.a = ia[1][7:0];    assign bus1.b = ib[1][7:0];
  assign bus2.a = ia[2][11:0];   assign bus2.b = ib[2][11:0];

  assign ov[0] = bus0.out_valid; assign ir[0] = bus0.in_ready; assign co[0] = bus0.c_out; assign of[0] = bus0.ovf;
  assign ov[1] = bus1.out_valid; assign ir[1] = bus1.in_ready; assign co[1] = bus1.c_out; assign of[1] = bus1.ovf;
  assign ov[2] = bus2.out_valid; assign ir[2] = bus2.in_ready; assign co[2] = bus2.c_out; assign of[2] = bus2.ovf;
  assign sm[0] = bus0.sum;
  assign sm[1] = {24'd0, bus1.sum};
  assign sm[2] = {20'd0, bus2.sum};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, c_out, sum} for a w-bit add.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input int w);
    logic [63:0] mask;
    logic [63:0] t;
    logic [63:0] s;
    logic        o;
    mask = (64'd1 << w) - 64'd1;
    t    = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, cin};
    s    = t & mask;
    o    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {o, t[w], s[31:0]};
  endfunction

  task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    check("in_ready_before_accept", {63'd0, ir[sel]}, 64'd1);
    iv[sel] = 1'b1; ia[sel] = a; ib[sel] = b; ic[sel] = cin;
    @(posedge clk);
    @(negedge clk);
    iv[sel] = 1'b0;
  endtask

  // Counts edges after the acceptance edge until out_valid, bounded.
  task automatic wait_result(input int sel, output int n);
    n = 0;
    while (!ov[sel] && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume(input int sel);
    ordy[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[sel] = 1'b0;
  endtask

  task automatic full_op(input int sel, input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input int stall, input logic [31:0] es,
                         input logic ec, input logic eo);
    int n;
    start_op(sel, a, b, cin);
    wait_result(sel, n);
    check({tag, "_latency"}, 64'(n), 64'(lat[sel]));
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_valid"}, {63'd0, ov[sel]}, 64'd1);
    check({tag, "_sum"},   {32'd0, sm[sel]}, {32'd0, es});
    check({tag, "_c_out"}, {63'd0, co[sel]}, {63'd0, ec});
    check({tag, "_ovf"},   {63'd0, of[sel]}, {63'd0, eo});
    consume(sel);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [33:0] e;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ic[i] = 1'b0; ordy[i] = 1'b0; ia[i] = '0; ib[i] = '0;
    end

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", {63'd0, ov[0]}, 64'd0);
      check("rst_sum",       {32'd0, sm[0]}, 64'd0);
      check("rst_c_out",     {63'd0, co[0]}, 64'd0);
      check("rst_ovf",       {63'd0, of[0]}, 64'd0);
      check("rst_in_ready",  {63'd0, ir[0]}, 64'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", {63'd0, ov[0]}, 64'd0);
    check("post_rst_in_ready",  {63'd0, ir[0]}, 64'd1);
    check("post_rst_sum",       {32'd0, sm[0]}, 64'd0);

    // Directed vectors.
    full_op(0, "ripple",   32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 32'h0000_0100, 1'b0, 1'b0);
    full_op(0, "fullcarry",32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 32'h0000_0000, 1'b1, 1'b0);
    full_op(0, "posovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h8000_0000, 1'b0, 1'b1);
    full_op(0, "negovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b1);
    full_op(1, "c1_wrap",  32'h0000_00F0, 32'h0000_0011, 1'b1, 0, 32'h0000_0002, 1'b1, 1'b0);
    full_op(2, "w4c3",     32'h0000_07FF, 32'h0000_0001, 1'b0, 0, 32'h0000_0800, 1'b0, 1'b1);

    // Backpressure: 0x7FFFFFFF + 0x7FFFFFFF + 1 = 0xFFFFFFFF, overflow.
    start_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    wait_result(0, n);
    check("bp_latency", 64'(n), 64'd4);
    for (int k = 0; k < 10; k++) begin
      check("bp_valid",    {63'd0, ov[0]}, 64'd1);
      check("bp_in_ready", {63'd0, ir[0]}, 64'd0);
      check("bp_sum",      {32'd0, sm[0]}, 64'hFFFF_FFFF);
      check("bp_c_out",    {63'd0, co[0]}, 64'd0);
      check("bp_ovf",      {63'd0, of[0]}, 64'd1);
      iv[0] = k[0]; ia[0] = 32'hDEAD_0000 + 32'(k); ib[0] = 32'h0BAD_F00D;
      @(posedge clk);
      @(negedge clk);
    end
    iv[0] = 1'b1; ia[0] = 32'd1; ib[0] = 32'd2; ic[0] = 1'b0; ordy[0] = 1'b1;
    #1;
    check("b2b_in_ready", {63'd0, ir[0]}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0; ordy[0] = 1'b0;
    check("b2b_valid_drop", {63'd0, ov[0]}, 64'd0);
    wait_result(0, n);
    check("b2b_latency", 64'(n), 64'd4);
    check("b2b_sum",     {32'd0, sm[0]}, 64'd3);
    check("b2b_c_out",   {63'd0, co[0]}, 64'd0);
    consume(0);

    // Reset after two slices have been processed.
    start_op(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid",    {63'd0, ov[0]}, 64'd0);
    check("midrst_in_ready", {63'd0, ir[0]}, 64'd1);
    repeat (2) begin
      @(negedge clk);
      check("midrst_hold_valid", {63'd0, ov[0]}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_valid", {63'd0, ov[0]}, 64'd0);
    end
    full_op(0, "after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 0, 32'h2345_6789, 1'b0, 1'b0);

    // Random operations with random result stalls in each configuration.
    for (int sel = 0; sel < 3; sel++) begin
      for (int k = 0; k < ((sel == 0) ? 100 : 40); k++) begin
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        e  = model(ra, rb, rc, wd[sel]);
        full_op(sel, "rand", ra & ((64'd1 << wd[sel]) - 1) , rb & ((64'd1 << wd[sel]) - 1), rc,
                int'($urandom_range(0, 3)), e[31:0], e[32], e[33]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
